// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state encoding and default width.
package seq_mult_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: multiplicand/multiplier/accumulator registers, partial-product gate and adder.
// With SEQ_MULT_EARLY_TERM_EN defined it also reports when the remaining multiplier bits are exhausted.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_EARLY_TERM_EN
    output logic                 mplier_done,
`endif
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] sum;

    // Carry out of the top bit cannot occur for an exact WIDTH x WIDTH product.
    assign partial = mcand & {(2*WIDTH){mplier[0]}};
    assign sum     = acc + partial;

`ifdef SEQ_MULT_EARLY_TERM_EN
    // True when the multiplier will be zero after this step's shift.
    assign mplier_done = (mplier[WIDTH-1:1] == '0);
`endif

    always_ff @(posedge clk) begin
        if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (step) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= '0;
        end else if (step) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/seq_mult_32_bit_ctrl.sv
// Multi-cycle unsigned multiplier: IDLE/BUSY/DONE control FSM driving a one-bit-per-cycle shift-add datapath.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN (finish as soon as the remaining multiplier bits are zero).
module seq_mult_32_bit_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             load;
    logic             step;
    logic             last_step;

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic             mplier_done;
    assign last_step = (count == LAST_COUNT) || mplier_done;
`else
    assign last_step = (count == LAST_COUNT);
`endif

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .step        (step),
        .a           (A),
        .b           (B),
`ifdef SEQ_MULT_EARLY_TERM_EN
        .mplier_done (mplier_done),
`endif
        .acc         (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    // Any unreachable encoding falls back to IDLE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_mult_32_bit_ctrl.sv
// Randomized self-checking bench for seq_mult_32_bit_ctrl against an arithmetic product/latency model.
module tb_seq_mult_32_bit_ctrl;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult_32_bit_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W ($clog2(WIDTH) + 1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Edges from accept to out_valid, derived from the multiplier value alone.
    function automatic int exp_latency(input logic [WIDTH-1:0] bv);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int top = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bv[i]) top = i + 1;
        end
        return (top < 1) ? 1 : top;
`else
        return (bv === bv) ? WIDTH : WIDTH;
`endif
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input int stall, input bit hold_valid, input string tag);
        logic [63:0] exp_p;
        int          edges;
        bit          seen;
        exp_p = {32'b0, av} * {32'b0, bv};
        @(negedge clk);
        edges = 0;
        while (!in_ready && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check_val({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid = 1'b0;
        @(negedge clk);
        check_val({tag, " busy_after_accept"}, {62'd0, busy, in_ready}, 64'd2);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (hold_valid) begin
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        in_valid = 1'b0;
        check_val({tag, " out_valid_seen"}, 64'(seen), 64'd1);
        check_val({tag, " latency"}, 64'(edges), 64'(exp_latency(bv)));
        check_val({tag, " product"}, product, exp_p);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            check_val({tag, " stall_hold"}, {out_valid, in_ready, busy, product[60:0]},
                      {1'b1, 1'b0, 1'b0, exp_p[60:0]});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_val({tag, " back_to_idle"}, {61'd0, in_ready, out_valid, busy}, 64'd4);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1 rst_n = 1'b0;
        #1;
        check_val("reset_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check_val("reset_product", product, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd3, 32'd5, 0, 1'b0, "t1_3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, "t2_max");
        run_op(32'h1234_5678, 32'd0, 10, 1'b0, "t3_zero_stall");

        // Reset in the middle of an operation.
        @(negedge clk);
        a        = $urandom;
        b        = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check_val("t4_busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("t4_reset_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check_val("t4_reset_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd7, 32'd6, 1, 1'b0, "t4_after_reset");

        run_op(32'hDEAD_BEEF, 32'h0001_2345, 3, 1'b1, "t5_hold_valid");
        run_op(32'd9, 32'd1, 0, 1'b0, "t6_b_one");
        run_op(32'hCAFE_F00D, 32'h8000_0000, 0, 1'b0, "t6_b_msb");

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, $urandom_range(0, 3), bit'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
